// File: rtl/stack_spill.sv
// Small on-chip LIFO that spills its oldest entries to external memory and refills them on demand.
// Push/pop take effect on the clock edge; ready drops while a spill/fill is pending or in flight.
module stack_spill #(
    parameter int          l    = 16,
    parameter int          dep  = 2,
    parameter int          aw   = 4,
    parameter logic [15:0] base = 16'h0100
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [l-1:0]  din,
    output logic [l-1:0]  dout,
    output logic          ready,
    output logic [aw+1:0] level,
    output logic          ovf,
    output logic          unf,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [15:0]   mem_addr,
    output logic [l-1:0]  mem_wdata,
    input  logic [l-1:0]  mem_rdata,
    input  logic          mem_ack
);
    localparam int N    = 1 << dep;
    localparam int SMAX = 1 << aw;

    localparam logic [dep:0]  CNT_HI = (dep+1)'(N - 1);
    localparam logic [dep:0]  CNT_LO = (dep+1)'(1);
    localparam logic [aw:0]   SD_MAX = (aw+1)'(SMAX);
    localparam logic [aw+1:0] LV_MAX = (aw+2)'(N + SMAX);

    typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

    state_t          state;
    logic [dep-1:0]  sp;
    logic [dep:0]    cnt;
    logic [aw:0]     sd;
    logic [l-1:0]    stk [N];

    logic            spill_req;
    logic            fill_req;
    logic [dep-1:0]  bot;
    logic            wr_en;
    logic [dep-1:0]  wr_idx;
    logic [l-1:0]    wr_dat;

    assign bot       = sp - cnt[dep-1:0] + dep'(1);
    assign spill_req = (cnt >= CNT_HI) && (sd < SD_MAX);
    assign fill_req  = (cnt <= CNT_LO) && (sd != '0);
    assign ready     = (state == IDLE) && !spill_req && !fill_req;
    assign level     = (aw+2)'(sd) + (aw+2)'(cnt);
    assign dout      = (cnt == '0) ? '0 : stk[sp];

    // Single buffer write port shared by accepted pushes and completed fills.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = sp;
        wr_dat = din;
        if (ready && push) begin
            if (pop && cnt != '0) begin
                wr_en  = 1'b1;
                wr_idx = sp;
            end else if (level < LV_MAX) begin
                wr_en  = 1'b1;
                wr_idx = sp + dep'(1);
            end
        end else if (state == FILL && mem_ack) begin
            wr_en  = 1'b1;
            wr_idx = bot - dep'(1);
            wr_dat = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            stk[wr_idx] <= wr_dat;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sp        <= '0;
            cnt       <= '0;
            sd        <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= base;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (spill_req) begin
                        state     <= SPILL;
                        mem_wr    <= 1'b1;
                        mem_addr  <= base + 16'({sd, 1'b0});
                        mem_wdata <= stk[bot];
                    end else if (fill_req) begin
                        state    <= FILL;
                        mem_rd   <= 1'b1;
                        mem_addr <= base + 16'({sd - (aw+1)'(1), 1'b0});
                    end else if (!(push && pop && cnt != '0)) begin
                        // Same-cycle push+pop with data on chip is a pure TOS overwrite.
                        if (pop && level == '0)
                            unf <= 1'b1;
                        if (push) begin
                            if (level < LV_MAX) begin
                                sp  <= sp + dep'(1);
                                cnt <= cnt + (dep+1)'(1);
                            end else begin
                                ovf <= 1'b1;
                            end
                        end else if (pop && cnt != '0) begin
                            sp  <= sp - dep'(1);
                            cnt <= cnt - (dep+1)'(1);
                        end
                    end
                end
                SPILL: begin
                    if (mem_ack) begin
                        state  <= IDLE;
                        mem_wr <= 1'b0;
                        cnt    <= cnt - (dep+1)'(1);
                        sd     <= sd + (aw+1)'(1);
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        state  <= IDLE;
                        mem_rd <= 1'b0;
                        cnt    <= cnt + (dep+1)'(1);
                        sd     <= sd - (aw+1)'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_spill.sv
// Randomised bench for stack_spill: the whole stack is kept as one queue, the bottom
// (size - cnt) entries being the ones that live in spill memory.
module tb_stack_spill;
    logic        clk = 1'b0;
    logic        reset;
    logic        push, pop, mem_ack;
    logic [15:0] din, mem_rdata;
    logic [15:0] dout, mem_addr, mem_wdata;
    logic        ready, ovf, unf, mem_rd, mem_wr;
    logic [5:0]  level;

    stack_spill dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
        .dout(dout), .ready(ready), .level(level), .ovf(ovf), .unf(unf),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Reference: full stack contents, on-chip count, pending transfer (0 none, 1 spill, 2 fill).
    logic [15:0] q[$];
    int          m_cnt;
    int          m_busy;
    bit          m_ovf, m_unf;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int m_sd();
        return q.size() - m_cnt;
    endfunction

    function automatic bit m_ready();
        return m_busy == 0 && !(m_cnt >= 3 && m_sd() < 16) && !(m_cnt <= 1 && m_sd() > 0);
    endfunction

    function automatic logic [15:0] m_top();
        if (m_cnt > 0) return q[$];
        return 16'h0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_cnt  = 0;
        m_busy = 0;
        m_ovf  = 0;
        m_unf  = 0;
    endtask

    task automatic check_all();
        check("ready", ready, m_ready());
        check("level", level, q.size());
        check("dout", dout, m_top());
        check("ovf", ovf, m_ovf);
        check("unf", unf, m_unf);
        check("mem_wr", mem_wr, m_busy == 1);
        check("mem_rd", mem_rd, m_busy == 2);
        if (m_busy == 1) begin
            check("spill_addr", mem_addr, 16'h0100 + 2 * m_sd());
            check("spill_data", mem_wdata, q[m_sd()]);
        end else if (m_busy == 2) begin
            check("fill_addr", mem_addr, 16'h0100 + 2 * (m_sd() - 1));
        end
    endtask

    // One clock: drive at negedge, advance the model, check at the next negedge.
    task automatic cycle(input bit p, input bit po, input logic [15:0] d, input bit a);
        int sd;
        sd = m_sd();
        push = p; pop = po; din = d; mem_ack = a;
        mem_rdata = (m_busy == 2) ? q[sd - 1] : 16'($urandom);
        case (m_busy)
            0: begin
                if (m_cnt >= 3 && sd < 16) m_busy = 1;
                else if (m_cnt <= 1 && sd > 0) m_busy = 2;
                else if (p && po && m_cnt > 0) q[q.size() - 1] = d;
                else begin
                    if (po && q.size() == 0) m_unf = 1;
                    if (p) begin
                        if (q.size() < 20) begin q.push_back(d); m_cnt++; end
                        else m_ovf = 1;
                    end else if (po && m_cnt > 0) begin
                        void'(q.pop_back());
                        m_cnt--;
                    end
                end
            end
            1: if (a) begin m_cnt--; m_busy = 0; end
            default: if (a) begin m_cnt++; m_busy = 0; end
        endcase
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic apply_reset();
        reset = 1'b1; push = 0; pop = 0; mem_ack = 0; din = 0; mem_rdata = 0;
        #1;
        model_reset();
        check("rst_mem_wr", mem_wr, 0);
        check("rst_level", level, 0);
        check("rst_ready", ready, 1);
        check("rst_dout", dout, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 check_all();
    endtask

    initial begin
        int v;
        int pp, pr;
        reset = 1'b1; push = 0; pop = 0; mem_ack = 0; din = 0; mem_rdata = 0;
        model_reset();
        @(negedge clk);
        check("init_ovf", ovf, 0);
        check("init_unf", unf, 0);
        apply_reset();

        // Fill to the spill threshold and complete one spill.
        cycle(1, 0, 16'd1, 0);
        cycle(1, 0, 16'd2, 0);
        cycle(1, 0, 16'd3, 0);
        check("s1_ready_low", ready, 0);
        cycle(0, 0, 16'd0, 0);
        check("s1_mem_wr", mem_wr, 1);
        check("s1_addr", mem_addr, 16'h0100);
        check("s1_wdata", mem_wdata, 16'd1);
        cycle(0, 0, 16'd0, 1);
        check("s1_level", level, 3);
        check("s1_ready", ready, 1);

        // Pop twice; the second is held off by the refill.
        cycle(0, 1, 16'd0, 0);
        check("f1_ready_low", ready, 0);
        cycle(0, 1, 16'd0, 0);
        check("f1_mem_rd", mem_rd, 1);
        check("f1_addr", mem_addr, 16'h0100);
        cycle(0, 0, 16'd0, 1);
        check("f1_level", level, 2);
        check("f1_dout", dout, 16'd2);

        // TOS overwrite, then drain to empty and underflow.
        cycle(1, 1, 16'hBEEF, 0);
        check("ow_dout", dout, 16'hBEEF);
        check("ow_level", level, 2);
        cycle(0, 1, 16'd0, 0);
        cycle(0, 1, 16'd0, 0);
        cycle(0, 1, 16'd0, 0);
        check("unf_flag", unf, 1);
        check("unf_level", level, 0);
        check("unf_dout", dout, 0);

        // Fill to capacity with the memory always acknowledging.
        apply_reset();
        v = 1;
        for (int k = 0; k < 300 && v <= 21; k++) begin
            bit acc;
            acc = m_ready();
            cycle(1, 0, 16'(v), 1);
            if (acc) v++;
        end
        check("full_done", v > 21, 1);
        check("full_level", level, 20);
        check("full_ovf", ovf, 1);
        check("full_dout", dout, 16'd20);

        // Reset while a spill waits for its acknowledge.
        apply_reset();
        cycle(1, 0, 16'd7, 0);
        cycle(1, 0, 16'd8, 0);
        cycle(1, 0, 16'd9, 0);
        cycle(0, 0, 16'd0, 0);
        check("rs_mem_wr_pre", mem_wr, 1);
        apply_reset();
        cycle(0, 0, 16'd0, 1);

        // Random traffic: push-heavy, pop-heavy, then balanced.
        for (int ph = 0; ph < 3; ph++) begin
            pp = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
            pr = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
            for (int k = 0; k < 500; k++)
                cycle($urandom_range(0, 99) < pp, $urandom_range(0, 99) < pr,
                      16'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
